bus_transfer_ctrl: RTL and testbench
====================================

Name: bus_transfer_ctrl

Overview:
Downstream consumer and controller for the 4-source common bus. It accepts transfer commands (source, destination) through a valid/ready port and buffers them in a small FIFO. For each command it drives the bus select lines s1:s0, waits one cycle for the bus output to settle, then captures the bus word into one of four destination registers. It sits between the microoperation sequencer and the common bus, so register-to-register transfers run back-to-back without a software-timed select.

Parameters:
WIDTH, 4, bus word width in bits; also the width of each destination register.
DEPTH, 4, command FIFO depth in entries; must be a power of two, at least 2.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
clr  in  1  synchronous active-high reset.
cmd_valid  in  1  a command is presented on cmd_src/cmd_dst.
cmd_ready  out  1  FIFO can accept a command this cycle.
cmd_src  in  2  bus source to select (0=a, 1=b, 2=c, 3=d).
cmd_dst  in  2  destination register index (0..3).
s1  out  1  bus select MSB, registered.
s0  out  1  bus select LSB, registered.
bus_data  in  WIDTH  bus output word (o3..o0 packed, o0 = bit 0).
r0  out  WIDTH  destination register 0.
r1  out  WIDTH  destination register 1.
r2  out  WIDTH  destination register 2.
r3  out  WIDTH  destination register 3.
busy  out  1  high in SELECT or LOAD, or whenever the FIFO is non-empty.
done  out  1  one-cycle pulse, the cycle after a destination register is written.

Behaviour:
- Clocking and reset: single clock clk. clr is synchronous and active-high.
- Reset (clr=1 at an edge):
  - state=IDLE, FIFO empty (pointers and count 0).
  - s1=s0=0, r0..r3=0, done=0.
  - cmd_ready is forced low combinationally while clr=1.
  - Any in-flight transfer is abandoned, with no register write.
  - clr has priority over every other event.
- FIFO:
  - Push on an edge where cmd_valid && cmd_ready. Each entry is {src,dst}, 4 bits.
  - cmd_ready = (count != DEPTH) && !clr.
  - When full, cmd_ready is low even if a pop occurs in the same cycle. There is no full-bypass.
  - There is no empty-bypass: a command pushed at edge k is popped at edge k+1 at the earliest.
  - A push and a pop on the same edge leave count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, SELECT, LOAD.
  - IDLE: if FIFO is non-empty, pop the head, latch src/dst, load s1:s0 <= src, go to SELECT. Otherwise stay in IDLE.
  - SELECT: one settle cycle, with s1:s0 stable. Unconditionally go to LOAD.
  - LOAD: on the edge leaving LOAD, r[dst] <= bus_data and done <= 1.
    - If the FIFO is non-empty (evaluated after any same-edge push is excluded), pop the next entry, load s1:s0 <= new src, go to SELECT.
    - Otherwise go to IDLE.
- done: high for exactly the cycle after each write, otherwise 0.
- Latency: push at edge k gives s1:s0 valid after edge k+1 and the register written at edge k+3. Sustained throughput is 1 transfer per 2 cycles.
- s1:s0 hold their last value in IDLE. They change only on a pop.
- Only the addressed destination register changes on a write; the other three hold.
- src==dst index is legal: a normal transfer with no special case.
- bus_data is sampled only on the LOAD edge. Changes at any other time are ignored.
- busy = (state != IDLE) || (count != 0).

Test Plan:
- Reset: hold clr=1 for 2 cycles with cmd_valid=1 -> cmd_ready=0, s1=s0=0, r0..r3=0, done=0, FIFO stays empty after clr drops.
- Single transfer: bench bus model returns a=1, b=2, c=3, d=4. Push {src=2,dst=1} at edge k -> s1:s0=10 after edge k+1, r1=3 after edge k+3, done high for one cycle, r0/r2/r3 stay 0.
- Back-to-back: push {0,0},{1,1},{2,2},{3,3} on consecutive cycles -> r0=1, r1=2, r2=3, r3=4, written 2 cycles apart, 4 done pulses, busy low after the last.
- Full FIFO: stall progress by pushing 4 commands before the first pop completes, hold cmd_valid -> cmd_ready=0 while count=4; the 5th command is accepted only after a pop; no command is lost or duplicated.
- Reset mid-transfer: push {3,2}, assert clr in SELECT -> r2 stays 0, no done pulse, state IDLE, FIFO empty.
- Bus change outside LOAD: toggle bus_data during SELECT, hold 4'hA through the LOAD edge -> the destination captures 4'hA.

Source files
------------

// File: rtl/bus_transfer_ctrl.sv
// bus_transfer_ctrl
//   Consumer/controller for the 4-source common bus. Transfer commands
//   {src, dst} are queued in a small FIFO; for each one the bus select
//   lines are driven, one settle cycle is allowed, then the bus word is
//   captured into the addressed destination register.
//
// Ports
//   clk        system clock, rising edge
//   clr        synchronous active-high reset
//   cmd_valid  command present on cmd_src/cmd_dst
//   cmd_ready  FIFO can accept a command (low while clr is high)
//   cmd_src    bus source to select (0=a, 1=b, 2=c, 3=d)
//   cmd_dst    destination register index
//   s1, s0     registered bus select
//   bus_data   bus output word
//   r0..r3     destination registers
//   busy       transfer in progress or commands pending
//   done       one-cycle pulse after a destination register write
module bus_transfer_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_src,
  input  logic [1:0]       cmd_dst,
  output logic             s1,
  output logic             s0,
  input  logic [WIDTH-1:0] bus_data,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic             busy,
  output logic             done
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, SELECT, LOAD} state_t;

  state_t           state;
  logic [3:0]       mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic [1:0]       sel;
  logic [1:0]       dst;
  logic [WIDTH-1:0] regs [4];
  logic             push;
  logic             pop;
  logic [3:0]       head;

  assign cmd_ready = (count != FULL) && !clr;
  assign push      = cmd_valid && cmd_ready;
  // count is the registered value, so a command pushed on this edge is
  // never visible to the pop decision on the same edge.
  assign pop       = (count != '0) && ((state == IDLE) || (state == LOAD));
  assign head      = mem[rptr];
  assign busy      = (state != IDLE) || (count != '0);

  assign {s1, s0} = sel;
  assign r0 = regs[0];
  assign r1 = regs[1];
  assign r2 = regs[2];
  assign r3 = regs[3];

  // FIFO storage: no reset needed, push is already gated by clr.
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= {cmd_src, cmd_dst};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      sel   <= '0;
      dst   <= '0;
      done  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++)
        regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            sel   <= head[3:2];
            dst   <= head[1:0];
            state <= SELECT;
          end
        end
        SELECT: state <= LOAD;
        LOAD: begin
          regs[dst] <= bus_data;
          done      <= 1'b1;
          if (pop) begin
            sel   <= head[3:2];
            dst   <= head[1:0];
            state <= SELECT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// tb_bus_transfer_ctrl
//   Directed and random stimulus for bus_transfer_ctrl. The reference model
//   tracks each accepted command by its push edge and predicted write edge:
//   write = max(push + 3, previous write + 2), pop = write - 2.
module tb_bus_transfer_ctrl;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             clr = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_src = '0;
  logic [1:0]       cmd_dst = '0;
  logic             s1, s0;
  logic [WIDTH-1:0] bus_data;
  logic [WIDTH-1:0] r0, r1, r2, r3;
  logic             busy, done;

  // bus model: sources a..d, optionally overridden
  logic [WIDTH-1:0] src_val [4];
  logic             ovr = 1'b0;
  logic [WIDTH-1:0] ovr_val = '0;

  assign bus_data = ovr ? ovr_val : src_val[{s1, s0}];

  always #5 clk = ~clk;

  bus_transfer_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .s1(s1), .s0(s0),
    .bus_data(bus_data), .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .busy(busy), .done(done)
  );

  typedef struct {
    int         p;
    int         w;
    logic [1:0] s;
    logic [1:0] d;
  } cmd_t;

  cmd_t             q[$];
  int               last_w = -100;
  int               cyc = 0;
  int               total = 0;
  int               bad = 0;
  logic [WIDTH-1:0] exp_r [4];
  logic [1:0]       exp_sel;
  logic             exp_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at edge %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  // commands sitting in the FIFO just before edge e
  function automatic int count_before(input int e);
    int n = 0;
    foreach (q[i])
      if (q[i].p < e && q[i].w - 2 >= e) n++;
    return n;
  endfunction

  function automatic logic exp_busy(input int e);
    logic b = 1'b0;
    foreach (q[i])
      if (q[i].p <= e && q[i].w > e) b = 1'b1;
    return b;
  endfunction

  task automatic tick(input logic v, input logic [1:0] s, input logic [1:0] d, input logic c);
    int   e;
    int   w;
    logic exp_ready;
    logic acc;
    cmd_t t;
    cmd_valid = v;
    cmd_src   = s;
    cmd_dst   = d;
    clr       = c;
    #1;
    e = cyc + 1;
    exp_ready = !c && (count_before(e) != DEPTH);
    check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    acc = v && exp_ready;
    @(posedge clk);
    cyc = e;
    if (c) begin
      q.delete();
      last_w   = -100;
      exp_sel  = '0;
      exp_done = 1'b0;
      for (int i = 0; i < 4; i++) exp_r[i] = '0;
    end else begin
      exp_done = 1'b0;
      foreach (q[i]) begin
        if (q[i].w == e) begin
          exp_r[q[i].d] = ovr ? ovr_val : src_val[q[i].s];
          exp_done = 1'b1;
        end
        if (q[i].w - 2 == e) exp_sel = q[i].s;
      end
      if (acc) begin
        w = (e + 3 > last_w + 2) ? e + 3 : last_w + 2;
        t.p = e; t.w = w; t.s = s; t.d = d;
        q.push_back(t);
        last_w = w;
      end
    end
    #1;
    check("r0", 32'(r0), 32'(exp_r[0]));
    check("r1", 32'(r1), 32'(exp_r[1]));
    check("r2", 32'(r2), 32'(exp_r[2]));
    check("r3", 32'(r3), 32'(exp_r[3]));
    check("sel", 32'({s1, s0}), 32'(exp_sel));
    check("done", 32'(done), 32'(exp_done));
    check("busy", 32'(busy), 32'(exp_busy(e)));
    while (q.size() > 0 && q[0].w <= e) void'(q.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 2'd0, 2'd0, 1'b0);
  endtask

  initial begin
    src_val[0] = 4'd1; src_val[1] = 4'd2; src_val[2] = 4'd3; src_val[3] = 4'd4;

    // reset with cmd_valid held high
    tick(1'b1, 2'd1, 2'd2, 1'b1);
    tick(1'b1, 2'd1, 2'd2, 1'b1);
    idle(2);

    // single transfer c -> r1
    tick(1'b1, 2'd2, 2'd1, 1'b0);
    idle(5);

    // back-to-back, one per register
    tick(1'b1, 2'd0, 2'd0, 1'b0);
    tick(1'b1, 2'd1, 2'd1, 1'b0);
    tick(1'b1, 2'd2, 2'd2, 1'b0);
    tick(1'b1, 2'd3, 2'd3, 1'b0);
    idle(10);

    // fill the FIFO by holding cmd_valid
    for (int i = 0; i < 14; i++)
      tick(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
    idle(14);

    // reset while in SELECT
    tick(1'b1, 2'd3, 2'd2, 1'b0);
    idle(1);
    tick(1'b0, 2'd0, 2'd0, 1'b1);
    idle(4);

    // bus toggles during SELECT, holds 4'hA over the LOAD edge
    tick(1'b1, 2'd1, 2'd3, 1'b0);
    ovr = 1'b1;
    ovr_val = 4'h5;
    idle(1);
    ovr_val = 4'($urandom);
    #2;
    ovr_val = 4'h7;
    idle(1);
    ovr_val = 4'hA;
    idle(1);
    ovr = 1'b0;
    check("bus_hold", 32'(r3), 32'(4'hA));
    idle(3);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0)
        for (int k = 0; k < 4; k++) src_val[k] = 4'($urandom);
      tick(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 49) == 0));
    end
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
